// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, default sizes and the
// clog2-based width helper used to size grant indices and the timeout counter.
package uart_tx_arbiter_pkg;

   typedef enum logic [0:0] {
      StIdle,
      StStream
   } arb_state_e;

   localparam int unsigned NreqDefault    = 4;
   localparam int unsigned DbitsDefault   = 8;
   localparam int unsigned TimeoutDefault = 1024;

   // clog2 that never returns 0, so a single requester still gets a 1-bit index.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned IdxWDefault = clog2_min1(NreqDefault);
   localparam int unsigned CntWDefault = clog2_min1(TimeoutDefault);

endpackage

// File: rtl/rr_select.sv
// Round-robin priority selector: picks the first set request bit searching upward from
// (last_i + 1) mod NREQ. Purely combinational.
module rr_select
   import uart_tx_arbiter_pkg::*;
#(
   parameter int unsigned NREQ = NreqDefault,
   parameter int unsigned IDXW = IdxWDefault
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IDXW-1:0] last_i,
   output logic [IDXW-1:0] grant_o,
   output logic            any_o
);

   int unsigned idx;

   // Walk offsets 1..NREQ from the last grantee; the first hit wins.
   always_comb begin
      grant_o = '0;
      any_o   = 1'b0;
      idx     = 0;
      for (int unsigned off = 1; off <= NREQ; off++) begin
         idx = (32'(last_i) + off) % NREQ;
         if (!any_o && req_i[IDXW'(idx)]) begin
            any_o   = 1'b1;
            grant_o = IDXW'(idx);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter in front of a UART Tx FIFO. One idle cycle arbitrates,
// then the grantee streams bytes with zero-latency writes until its last byte, or until it
// stays silent long enough for the timeout to revoke the grant.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int unsigned NREQ    = NreqDefault,
   parameter int unsigned DBITS   = DbitsDefault,
   parameter int unsigned TIMEOUT = TimeoutDefault
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic [NREQ-1:0]             req_valid,
   input  logic [NREQ*DBITS-1:0]       req_data,
   input  logic [NREQ-1:0]             req_last,
   output logic [NREQ-1:0]             req_ready,
   input  logic                        tx_full,
   output logic                        write_uart,
   output logic [DBITS-1:0]            write_data,
   output logic [clog2_min1(NREQ)-1:0] grant_id,
   output logic                        busy,
   output logic                        abort
);

   localparam int unsigned IdxW = clog2_min1(NREQ);
   localparam int unsigned CntW = clog2_min1(TIMEOUT);
   // Abort is registered, so it is decided the cycle the counter would step to TIMEOUT-1.
   localparam logic [CntW-1:0] CntAbort = CntW'(TIMEOUT - 2);
   localparam logic [IdxW-1:0] LastInit = IdxW'(NREQ - 1);

   arb_state_e      state_q, state_d;
   logic [IdxW-1:0] grant_id_q, grant_id_d;
   logic [IdxW-1:0] last_grant_q, last_grant_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            abort_q, abort_d;

   logic [IdxW-1:0]  rr_grant;
   logic             rr_any;
   logic             sel_valid;
   logic             sel_last;
   logic [DBITS-1:0] sel_data;
   logic             stream;
   logic             xfer;

   rr_select #(
      .NREQ (NREQ),
      .IDXW (IdxW)
   ) u_rr_select (
      .req_i   (req_valid),
      .last_i  (last_grant_q),
      .grant_o (rr_grant),
      .any_o   (rr_any)
   );

   // Route the current grantee's valid/last/data through a constant-index mux.
   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (IdxW'(i) == grant_id_q) begin
            sel_valid = req_valid[i];
            sel_last  = req_last[i];
            sel_data  = req_data[i*DBITS +: DBITS];
         end
      end
   end

   // Handshake outputs; gated by RST so a mid-packet reset cannot write in its own cycle.
   always_comb begin
      stream    = RST && (state_q == StStream);
      xfer      = stream && !tx_full && sel_valid;
      req_ready = '0;
      if (stream && !tx_full) begin
         req_ready[grant_id_q] = 1'b1;
      end
      write_uart = xfer;
      write_data = xfer ? sel_data : '0;
      busy       = stream;
      abort      = abort_q;
      grant_id   = grant_id_q;
   end

   // Next-state: arbitrate in idle, stream until last byte or silence timeout.
   always_comb begin
      state_d      = state_q;
      grant_id_d   = grant_id_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      abort_d      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (rr_any) begin
               grant_id_d = rr_grant;
               cnt_d      = '0;
               state_d    = StStream;
            end
         end
         StStream: begin
            if (xfer) begin
               cnt_d = '0;
               if (sel_last) begin
                  last_grant_d = grant_id_q;
                  state_d      = StIdle;
               end
            end else if (!tx_full && !sel_valid) begin
               // Silence only counts while the FIFO could have taken a byte.
               if (cnt_q == CntAbort) begin
                  abort_d      = 1'b1;
                  last_grant_d = grant_id_q;
                  cnt_d        = '0;
                  state_d      = StIdle;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with synchronous active-low reset; last grant starts at NREQ-1.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q      <= StIdle;
         grant_id_q   <= '0;
         last_grant_q <= LastInit;
         cnt_q        <= '0;
         abort_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_id_q   <= grant_id_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         abort_q      <= abort_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a vector table for single-cycle behaviour plus
// hand-written sequences for rotation, stalls, timeout and mid-packet reset.
module tb_uart_tx_arbiter;

   logic        CLK = 1'b0;
   logic        RST;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_last;
   logic [3:0]  req_ready;
   logic        tx_full;
   logic        write_uart;
   logic [7:0]  write_data;
   logic [1:0]  grant_id;
   logic        busy;
   logic        abort;

   int n_pass  = 0;
   int n_total = 0;
   logic chk_en = 1'b0;

   uart_tx_arbiter #(
      .NREQ    (4),
      .DBITS   (8),
      .TIMEOUT (16)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_last   (req_last),
      .req_ready  (req_ready),
      .tx_full    (tx_full),
      .write_uart (write_uart),
      .write_data (write_data),
      .grant_id   (grant_id),
      .busy       (busy),
      .abort      (abort)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      string       name;
      logic        rst;
      logic [3:0]  valid;
      logic [3:0]  last;
      logic        full;
      logic [31:0] data;
      logic        wr;
      logic [7:0]  wd;
      logic [3:0]  rdy;
      logic        bsy;
      logic [1:0]  gid;
      logic        abt;
   } vec_t;

   vec_t tv[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic next();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RST       = 1'b0;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      tx_full   = 1'b0;
      next();
      next();
      RST = 1'b1;
   endtask

   // Invariants checked every cycle once the design is out of its first reset.
   always @(negedge CLK) begin
      if (chk_en) begin
         chk("inv_wr_not_full", {31'b0, write_uart && tx_full}, 32'd0);
         chk("inv_ready_onehot0", {31'b0, $onehot0(req_ready)}, 32'd1);
      end
   end

   int cnt[4];
   logic [3:0] acc;

   initial begin
      // Rows are one cycle each; data bytes are per-requester in 8-bit lanes.
      tv[0] = '{"a_idle", 1, 4'b0001, 4'b0000, 0, 32'h41, 0, 8'h00, 4'b0000, 0, 2'd0, 0};
      tv[1] = '{"a_b0",   1, 4'b0001, 4'b0000, 0, 32'h41, 1, 8'h41, 4'b0001, 1, 2'd0, 0};
      tv[2] = '{"a_b1",   1, 4'b0001, 4'b0000, 0, 32'h42, 1, 8'h42, 4'b0001, 1, 2'd0, 0};
      tv[3] = '{"a_b2",   1, 4'b0001, 4'b0001, 0, 32'h43, 1, 8'h43, 4'b0001, 1, 2'd0, 0};
      tv[4] = '{"r_idle", 1, 4'b0100, 4'b0000, 0, 32'h0077_0000, 0, 8'h00, 4'b0000, 0,
                2'd0, 0};
      tv[5] = '{"r_full", 1, 4'b0110, 4'b0000, 1, 32'h0077_6600, 0, 8'h00, 4'b0000, 1,
                2'd2, 0};
      tv[6] = '{"r_go",   1, 4'b0110, 4'b0100, 0, 32'h0077_6600, 1, 8'h77, 4'b0100, 1,
                2'd2, 0};
      tv[7] = '{"r_idl2", 1, 4'b0010, 4'b0000, 0, 32'h0000_6600, 0, 8'h00, 4'b0000, 0,
                2'd2, 0};
      tv[8] = '{"r_g1",   1, 4'b0010, 4'b0010, 0, 32'h0000_6600, 1, 8'h66, 4'b0010, 1,
                2'd1, 0};
      tv[9] = '{"r_done", 1, 4'b0000, 4'b0000, 0, 32'h0, 0, 8'h00, 4'b0000, 0, 2'd1, 0};

      // Reset with everyone requesting: nothing may leak out.
      RST       = 1'b0;
      req_valid = 4'b1111;
      req_last  = 4'b0000;
      req_data  = 32'hDEAD_BEEF;
      tx_full   = 1'b0;
      next();
      @(negedge CLK);
      chk("rst_gid", 32'(grant_id), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_abort", 32'(abort), 32'd0);
      chk("rst_wr", 32'(write_uart), 32'd0);
      chk("rst_rdy", 32'(req_ready), 32'd0);
      chk_en = 1'b1;
      next();

      // Table: 3-byte packet from requester 0, then round-robin from last grant + 1.
      for (int i = 0; i < 10; i++) begin
         RST       = tv[i].rst;
         req_valid = tv[i].valid;
         req_last  = tv[i].last;
         tx_full   = tv[i].full;
         req_data  = tv[i].data;
         @(negedge CLK);
         chk({tv[i].name, ".wr"},   32'(write_uart), 32'(tv[i].wr));
         chk({tv[i].name, ".wd"},   32'(write_data), 32'(tv[i].wd));
         chk({tv[i].name, ".rdy"},  32'(req_ready),  32'(tv[i].rdy));
         chk({tv[i].name, ".busy"}, 32'(busy),       32'(tv[i].bsy));
         chk({tv[i].name, ".gid"},  32'(grant_id),   32'(tv[i].gid));
         chk({tv[i].name, ".abt"},  32'(abort),      32'(tv[i].abt));
         next();
      end

      // All four continuously valid with 2-byte packets: order 0,1,2,3,0.
      do_reset();
      for (int i = 0; i < 4; i++) cnt[i] = 0;
      for (int p = 0; p < 5; p++) begin
         for (int c = 0; c < 3; c++) begin
            req_valid = 4'b1111;
            for (int i = 0; i < 4; i++) begin
               req_data[i*8 +: 8] = 8'((i << 4) | cnt[i]);
               req_last[i]        = (cnt[i] == 1);
            end
            @(negedge CLK);
            if (c == 0) begin
               chk("b_idle_wr", 32'(write_uart), 32'd0);
               chk("b_idle_busy", 32'(busy), 32'd0);
            end else begin
               chk("b_wr", 32'(write_uart), 32'd1);
               chk("b_wd", 32'(write_data), 32'(((p % 4) << 4) | (c - 1)));
               chk("b_gid", 32'(grant_id), 32'(p % 4));
               chk("b_rdy", 32'(req_ready), 32'(1 << (p % 4)));
            end
            acc = req_ready & req_valid;
            next();
            for (int i = 0; i < 4; i++) begin
               if (acc[i]) cnt[i] = (cnt[i] == 1) ? 0 : cnt[i] + 1;
            end
         end
      end

      // tx_full stall of 20 cycles mid-packet: no write, no ready, no abort.
      do_reset();
      req_valid = 4'b0001;
      req_data  = 32'h10;
      @(negedge CLK);
      chk("c_idle_busy", 32'(busy), 32'd0);
      next();
      @(negedge CLK);
      chk("c_b0_wr", 32'(write_uart), 32'd1);
      chk("c_b0_wd", 32'(write_data), 32'h10);
      next();
      req_data = 32'h11;
      req_last = 4'b0001;
      tx_full  = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge CLK);
         chk("c_stall_wr", 32'(write_uart), 32'd0);
         chk("c_stall_rdy", 32'(req_ready), 32'd0);
         chk("c_stall_abort", 32'(abort), 32'd0);
         chk("c_stall_busy", 32'(busy), 32'd1);
         next();
      end
      tx_full = 1'b0;
      @(negedge CLK);
      chk("c_b1_wr", 32'(write_uart), 32'd1);
      chk("c_b1_wd", 32'(write_data), 32'h11);
      chk("c_b1_rdy", 32'(req_ready), 32'b0001);
      next();
      req_valid = 4'b0000;
      req_last  = 4'b0000;
      @(negedge CLK);
      chk("c_end_busy", 32'(busy), 32'd0);
      chk("c_end_abort", 32'(abort), 32'd0);
      next();

      // Timeout: requester 2 sends one byte then goes silent; requester 3 waits.
      do_reset();
      req_valid = 4'b1100;
      req_data  = 32'h335A_0000;
      @(negedge CLK);
      chk("d_idle_busy", 32'(busy), 32'd0);
      next();
      @(negedge CLK);
      chk("d_xfer_wr", 32'(write_uart), 32'd1);
      chk("d_xfer_wd", 32'(write_data), 32'h5A);
      chk("d_xfer_gid", 32'(grant_id), 32'd2);
      next();
      req_valid = 4'b1000;
      for (int k = 1; k <= 15; k++) begin
         @(negedge CLK);
         chk("d_wait_abort", 32'(abort), 32'd0);
         chk("d_wait_busy", 32'(busy), 32'd1);
         chk("d_wait_wr", 32'(write_uart), 32'd0);
         next();
      end
      @(negedge CLK);
      chk("d_abort", 32'(abort), 32'd1);
      chk("d_abort_busy", 32'(busy), 32'd0);
      chk("d_abort_gid", 32'(grant_id), 32'd2);
      next();
      req_last = 4'b1000;
      @(negedge CLK);
      chk("d_after_abort", 32'(abort), 32'd0);
      chk("d_next_gid", 32'(grant_id), 32'd3);
      chk("d_next_wr", 32'(write_uart), 32'd1);
      chk("d_next_wd", 32'(write_data), 32'h33);
      chk("d_next_rdy", 32'(req_ready), 32'b1000);
      next();
      req_valid = 4'b0000;
      req_last  = 4'b0000;

      // Reset mid-packet of requester 1, then restart with 1 and 3 valid.
      do_reset();
      req_valid = 4'b0010;
      req_data  = 32'h0000_2200;
      @(negedge CLK);
      chk("e_idle_busy", 32'(busy), 32'd0);
      next();
      @(negedge CLK);
      chk("e_b0_wr", 32'(write_uart), 32'd1);
      chk("e_b0_wd", 32'(write_data), 32'h22);
      chk("e_b0_gid", 32'(grant_id), 32'd1);
      next();
      RST = 1'b0;
      @(negedge CLK);
      chk("e_rst_wr", 32'(write_uart), 32'd0);
      chk("e_rst_rdy", 32'(req_ready), 32'd0);
      chk("e_rst_busy", 32'(busy), 32'd0);
      next();
      RST       = 1'b1;
      req_valid = 4'b1010;
      req_data  = 32'h9900_2300;
      @(negedge CLK);
      chk("e_rel_busy", 32'(busy), 32'd0);
      chk("e_rel_gid", 32'(grant_id), 32'd0);
      chk("e_rel_abort", 32'(abort), 32'd0);
      next();
      @(negedge CLK);
      chk("e_g_gid", 32'(grant_id), 32'd1);
      chk("e_g_wr", 32'(write_uart), 32'd1);
      chk("e_g_wd", 32'(write_data), 32'h23);
      chk("e_g_rdy", 32'(req_ready), 32'b0010);
      next();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the UART transmit path.
REQ-002 Parameter DBITS, default 8, data bits per word; matches the UART core.
REQ-003 Parameter TIMEOUT, default 1024, idle cycles tolerated inside a packet before the grant is revoked.
REQ-004 Clocking and reset SHALL be: one clock; reset is synchronous and active-low.
REQ-005 CLK  input  1  system clock.
REQ-006 RST  input  1  synchronous active-low reset.
REQ-007 req_valid  input  NREQ  bit i set: requester i presents a byte.
REQ-008 req_data  input  NREQ*DBITS  byte of requester i in bits [i*DBITS +: DBITS].
REQ-009 req_last  input  NREQ  bit i set: the presented byte ends requester i's packet.
REQ-010 req_ready  output  NREQ  bit i set: requester i's byte is accepted this cycle.
REQ-011 tx_full  input  1  UART Tx FIFO full.
REQ-012 write_uart  output  1  write strobe to the UART Tx FIFO.
REQ-013 write_data  output  DBITS  byte to the UART Tx FIFO.
REQ-014 grant_id  output  clog2(NREQ)  current or most recent grantee.
REQ-015 busy  output  1  a packet is in progress.
REQ-016 abort  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-017 The state machine SHALL have two states, IDLE and STREAM.
REQ-018 IDLE, any req_valid set: select the first set bit searching round-robin from (last_grant+1) mod NREQ; register it into grant_id; enter STREAM next cycle.
REQ-019 No byte SHALL be accepted in the IDLE cycle; arbitration costs exactly one cycle per packet.
REQ-020 In STREAM, req_ready[grant_id] = !tx_full (combinational); all other req_ready bits SHALL be 0.
REQ-021 A transfer SHALL occur when req_valid[g] and req_ready[g] are both set.
- write_uart SHALL be asserted in the same cycle as the transfer (zero latency).
- write_data SHALL equal requester g's byte.
- Outside transfers, write_uart SHALL be 0 and write_data SHALL be 0.
REQ-022 write_uart SHALL never be asserted while tx_full=1.
REQ-023 A transfer with req_last[g]=1 SHALL return the machine to IDLE next cycle and update last_grant to g.
REQ-024 The grant SHALL persist across tx_full stalls indefinitely; no other requester SHALL interleave bytes within a packet.
REQ-025 Timeout counter:
- cleared on entry to STREAM and on every transfer;
- increments each STREAM cycle with req_valid[g]=0 and tx_full=0;
- holds while tx_full=1.
REQ-026 When the timeout counter reaches TIMEOUT-1: pulse abort for one cycle, set last_grant=g, go to IDLE; no write in that cycle.
REQ-027 busy SHALL be 1 exactly when the state is STREAM.
REQ-028 A requester dropping req_valid then raising it again within the timeout SHALL continue the same packet.
REQ-029 Packet-level fairness: with all requesters continuously valid, grants SHALL rotate 0,1,...,NREQ-1,0.
REQ-030 The timeout counter width SHALL be clog2(TIMEOUT); TIMEOUT SHALL be at least 2.

Reset
REQ-031 With RST=0 at a CLK edge, the block SHALL take: state IDLE, grant_id 0, last_grant NREQ-1 (so requester 0 wins first), timeout counter 0, abort 0.
REQ-032 During and after reset, the outputs write_uart, req_ready and busy SHALL be 0.
REQ-033 Reset mid-packet SHALL discard the grant with no write in the reset cycle; requesters restart packets.

Structure
REQ-034 The shared package SHALL hold the state encoding (IDLE, STREAM) and the clog2-based width constants.
REQ-035 The round-robin priority selector SHALL be one sub-module, rr_select.
- Inputs: request vector, last grant.
- Outputs: grant index, any-request flag.
- Purely combinational.

Verification
REQ-036 Reset release with req_valid=0001, 3-byte packet 0x41,0x42,0x43 (last on 0x43), tx_full=0: grant_id=0; writes on cycles 2,3,4 after valid; busy low at cycle 5.
REQ-037 All four requesters valid with 2-byte packets: packet order 0,1,2,3,0; no interleaving; one idle cycle between packets.
REQ-038 tx_full held high for 20 cycles mid-packet: write_uart=0 and req_ready=0 throughout; no abort; the packet resumes with the next byte intact.
REQ-039 TIMEOUT=16; requester 2 sends 1 byte without last, then drops valid: abort pulses 16 cycles after the last transfer; next grant goes to requester 3 if it is valid.
REQ-040 RST=0 asserted mid-packet of requester 1: no write that cycle; after release with 0010 and 1000 both valid, requester 0's priority slot applies and requester 1 is granted.
REQ-041 Assertion throughout all scenarios: write_uart implies !tx_full, and req_ready is one-hot or zero.
